// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port framebuffer RAM between pixel prefetch
// and CPU accesses, keeping a small pixel FIFO ahead of scan-out.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   frame_start               restart fetch at word 0, flush FIFO, clear underflow
//   pix_req -> pix_data/pix_valid   pop one word (result next cycle)
//   underflow                 sticky: pop attempted on an empty FIFO
//   cpu_req/cpu_we/cpu_addr/cpu_wdata -> cpu_ack/cpu_rdata   CPU access
//   mem_addr/mem_we/mem_wdata, mem_rdata   RAM port (read data one cycle late)
//
// Optional feature: define VRAM_ARB_STARVE_GUARD_EN to let a CPU request that
// has waited STARVE_LIMIT cycles override the low-water fill priority.
module vram_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned FB_WORDS     = 19200,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned LOW_WATER    = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_req,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underflow,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CPU   = 2'd2
  } state_t;

  // state: access issued this cycle; prev_state: access whose data returns now
  state_t state;
  state_t prev_state;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [LVL_W-1:0]  occ;
  logic [ADDR_W-1:0] fetch_addr;
  logic              cpu_ok;
  logic              push;
  logic              pop_try;
  logic              pop_ok;
  logic              starve;

  // No CPU grant in the ack cycle, so a still-high cpu_req is not issued twice
  assign cpu_ok  = cpu_req & ~cpu_ack;
  // A fetch returning in a frame_start cycle belongs to the old frame: drop it
  assign push    = (prev_state == FETCH) & ~frame_start;
  assign pop_try = pix_req & ~frame_start;
  assign pop_ok  = pop_try & (level != '0);
  assign occ     = level + LVL_W'(prev_state == FETCH);

  // RAM data is returned combinationally in the ack cycle
  assign cpu_rdata = cpu_ack ? mem_rdata : '0;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  // Cycles a grantable CPU request has been waiting; saturates at the limit
  always_ff @(posedge clk) begin
    if (rst || (state == CPU) || !cpu_ok) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Never starve the display completely: only override with data in the FIFO
  assign starve = (starve_cnt == CNT_W'(STARVE_LIMIT)) & (level != '0);
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^32'(STARVE_LIMIT);
  assign starve = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) prev_state <= IDLE;
    else     prev_state <= state;
  end

  // Grant decision and RAM port drive for the current cycle
  always_comb begin
    state     = IDLE;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (rst) begin
      state = IDLE;
    end else if (frame_start) begin
      if (cpu_ok) state = CPU;
    end else if (occ < LVL_W'(LOW_WATER)) begin
      state = (starve && cpu_ok) ? CPU : FETCH;
    end else if (cpu_ok) begin
      state = CPU;
    end else if (occ < LVL_W'(FIFO_DEPTH)) begin
      state = FETCH;
    end
    case (state)
      FETCH: mem_addr = fetch_addr;
      CPU: begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_wdata = cpu_wdata;
      end
      default: ;
    endcase
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (!rst && push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  // FIFO control, fetch address, pixel and CPU outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      fetch_addr <= '0;
      pix_data   <= '0;
      pix_valid  <= 1'b0;
      underflow  <= 1'b0;
      cpu_ack    <= 1'b0;
    end else begin
      cpu_ack   <= (state == CPU);
      pix_valid <= pop_ok;
      if (pop_ok) pix_data <= fifo_mem[rd_ptr];
      if (frame_start) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        level      <= '0;
        fetch_addr <= '0;
        underflow  <= 1'b0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
        level <= level + LVL_W'(push) - LVL_W'(pop_ok);
        if (pop_try && (level == '0)) underflow <= 1'b1;
        if (state == FETCH) begin
          fetch_addr <= (fetch_addr == ADDR_W'(FB_WORDS - 1)) ? '0
                                                              : fetch_addr + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed + randomized bench for vram_arbiter with a
// queue-based reference model; a second instance with FB_WORDS = 8 checks
// fetch address wrap.
module tb_vram_arbiter;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 16;
  localparam int unsigned FBW   = 19200;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = 2;
  localparam int unsigned SL    = 8;
  localparam int G_IDLE = 0, G_FETCH = 1, G_CPU = 2;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic          rst, frame_start, pix_req, cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] pix_data, cpu_rdata, mem_wdata, mem_rdata;
  logic          pix_valid, underflow, cpu_ack, mem_we;
  logic [AW-1:0] mem_addr;

  logic          pix_req8, frame_start8, cpu_req8, cpu_we8;
  logic [AW-1:0] cpu_addr8, mem_addr8;
  logic [DW-1:0] cpu_wdata8, pix_data8, cpu_rdata8, unused_wdata8, mem_rdata8;
  logic          pix_valid8, underflow8, cpu_ack8, mem_we8;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_WORDS(FBW), .FIFO_DEPTH(DEPTH),
                 .LOW_WATER(LW), .STARVE_LIMIT(SL)) u_dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_req(pix_req),
    .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_WORDS(8), .FIFO_DEPTH(DEPTH),
                 .LOW_WATER(LW), .STARVE_LIMIT(SL)) u_dut8 (
    .clk(clk), .rst(rst), .frame_start(frame_start8), .pix_req(pix_req8),
    .pix_data(pix_data8), .pix_valid(pix_valid8), .underflow(underflow8),
    .cpu_req(cpu_req8), .cpu_we(cpu_we8), .cpu_addr(cpu_addr8), .cpu_wdata(cpu_wdata8),
    .cpu_ack(cpu_ack8), .cpu_rdata(cpu_rdata8), .mem_addr(mem_addr8), .mem_we(mem_we8),
    .mem_wdata(unused_wdata8), .mem_rdata(mem_rdata8));

  // RAM behind each DUT: unwritten words read back as their own address
  bit            ram_written [65536];
  logic [DW-1:0] ram_data    [65536];
  always @(posedge clk) begin
    mem_rdata <= ram_written[mem_addr] ? ram_data[mem_addr] : mem_addr;
    if (mem_we) begin
      ram_written[mem_addr] <= 1'b1;
      ram_data[mem_addr]    <= mem_wdata;
    end
  end
  always @(posedge clk) mem_rdata8 <= mem_addr8;

  // Reference model
  bit            m_written [65536];
  logic [DW-1:0] m_wdat    [65536];
  logic [DW-1:0] m_fifo[$];
  bit            m_inf;
  logic [DW-1:0] m_inf_data;
  int unsigned   m_faddr;
  bit            m_ack, m_rd;
  logic [DW-1:0] m_rdata, m_pix;
  bit            m_pvalid, m_uflow;
  int            m_starve;

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] mread(input int unsigned a);
    return m_written[a] ? m_wdat[a] : DW'(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_inf = 0; m_faddr = 0; m_ack = 0; m_rd = 0; m_rdata = '0;
    m_pix = '0; m_pvalid = 0; m_uflow = 0; m_starve = 0;
  endtask

  function automatic int model_grant();
    bit cpu_ok;
    int occ;
    cpu_ok = cpu_req && !m_ack;
    occ    = m_fifo.size() + int'(m_inf);
    if (rst) return G_IDLE;
    if (frame_start) return cpu_ok ? G_CPU : G_IDLE;
    if (occ < int'(LW)) begin
`ifdef VRAM_ARB_STARVE_GUARD_EN
      if (m_starve >= int'(SL) && m_fifo.size() != 0 && cpu_ok) return G_CPU;
`endif
      return G_FETCH;
    end
    if (cpu_ok) return G_CPU;
    if (occ < int'(DEPTH)) return G_FETCH;
    return G_IDLE;
  endfunction

  task automatic model_update(input int g);
    bit new_valid;
    if (rst) begin
      model_reset();
      return;
    end
    new_valid = 0;
    if (frame_start) begin
      m_fifo.delete();
      m_uflow = 0;
    end else begin
      if (pix_req) begin
        if (m_fifo.size() > 0) begin
          m_pix = m_fifo.pop_front();
          new_valid = 1;
        end else begin
          m_uflow = 1;
        end
      end
      if (m_inf) m_fifo.push_back(m_inf_data);
    end
    m_pvalid = new_valid;
    m_inf = (g == G_FETCH);
    if (g == G_FETCH) begin
      m_inf_data = mread(m_faddr);
      m_faddr = (m_faddr == FBW - 1) ? 0 : m_faddr + 1;
    end
    if (frame_start) m_faddr = 0;
    if (cpu_req && !m_ack && g != G_CPU) m_starve = (m_starve < int'(SL)) ? m_starve + 1 : m_starve;
    else m_starve = 0;
    m_ack = (g == G_CPU);
    m_rd  = (g == G_CPU) && !cpu_we;
    if (g == G_CPU) begin
      m_rdata = mread(int'(cpu_addr));
      if (cpu_we) begin
        m_written[cpu_addr] = 1'b1;
        m_wdat[cpu_addr]    = cpu_wdata;
      end
    end
  endtask

  // One clock cycle: inputs already set after the falling edge
  task automatic tick();
    int g;
    #1;
    g = model_grant();
    check("mem_we", mem_we, (g == G_CPU) ? cpu_we : 1'b0);
    if (g == G_FETCH) check("fetch_addr", mem_addr, m_faddr);
    if (g == G_CPU) check("cpu_mem_addr", mem_addr, cpu_addr);
    if (g == G_CPU && cpu_we) check("mem_wdata", mem_wdata, cpu_wdata);
    check("cpu_ack", cpu_ack, m_ack);
    if (m_ack && m_rd) check("cpu_rdata", cpu_rdata, m_rdata);
    check("pix_valid", pix_valid, m_pvalid);
    check("pix_data", pix_data, m_pix);
    check("underflow", underflow, m_uflow);
    @(posedge clk);
    model_update(g);
    @(negedge clk);
  endtask

  bit            cpu_pend;
  int            acks;
  bit            found;
  logic [DW-1:0] rd;

  initial begin
    rst = 1; frame_start = 0; pix_req = 0; cpu_req = 0; cpu_we = 0;
    cpu_addr = '0; cpu_wdata = '0;
    pix_req8 = 0; frame_start8 = 0; cpu_req8 = 0; cpu_we8 = 0; cpu_addr8 = '0; cpu_wdata8 = '0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    tick();
    check("rst_cpu_ack8", cpu_ack8, 1'b0);
    rst = 0;

    // Idle after reset: FIFO fills with words 0..3, then stays idle
    repeat (10) tick();

    // Pops every second cycle on both instances
    for (int k = 0; k < 20; k++) begin
      pix_req = 1; pix_req8 = 1;
      tick();
      pix_req = 0; pix_req8 = 0;
      check("pop_data", pix_data, 32'(k));
      check("pop_valid", pix_valid, 1'b1);
      check("wrap_data", pix_data8, 32'(k % 8));
      check("wrap_valid", pix_valid8, 1'b1);
      check("wrap_mem_we", mem_we8, 1'b0);
      tick();
    end
    check("pop_underflow", underflow, 1'b0);
    check("wrap_underflow", underflow8, 1'b0);

    // CPU write then read of 0x0040 while popping
    for (int op = 0; op < 2; op++) begin
      found = 0;
      cpu_req = 1; cpu_we = (op == 0); cpu_addr = 16'h0040; cpu_wdata = 16'hBEEF;
      for (int c = 0; c < 20 && !found; c++) begin
        pix_req = (c % 2 == 0);
        tick();
        if (cpu_ack) begin
          found = 1;
          rd = cpu_rdata;
          cpu_req = 0;
        end
      end
      cpu_req = 0; pix_req = 0;
      check("cpu_op_acked", found, 1'b1);
      if (op == 1) check("cpu_read_beef", rd, 16'hBEEF);
    end
    check("cpu_no_underflow", underflow, 1'b0);

    // Randomized traffic against the model
    cpu_pend = 0;
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 999) < 2);
      frame_start = ($urandom_range(0, 99) < 2);
      pix_req = ($urandom_range(0, 99) < 55);
      if (rst || (cpu_pend && m_ack)) cpu_pend = 0;
      if (!rst && !cpu_pend && $urandom_range(0, 99) < 40) begin
        cpu_pend  = 1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 16'($urandom_range(16'h0100, 16'hFFFF));
        cpu_wdata = 16'($urandom);
      end
      cpu_req = cpu_pend;
      tick();
    end
    rst = 0; frame_start = 0; pix_req = 0; cpu_req = 0;
    tick();

    // Continuous pix_req with continuous CPU requests
    acks = 0;
    cpu_we = 1;
    for (int n = 0; n < 40; n++) begin
      pix_req = 1;
      cpu_req = 1;
      cpu_addr = 16'(16'h0200 + n);
      cpu_wdata = 16'(n);
      tick();
      if (cpu_ack) acks++;
    end
    cpu_req = 0; pix_req = 0;
    check("starve_cpu_granted", acks > 0, 1'b1);
    for (int n = 0; n < 5; n++) begin
      tick();
      check("underflow_sticky", underflow, 1'b1);
    end

    // frame_start with a fetch in flight and a pix_req in the same cycle
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (m_inf) found = 1;
      else begin
        pix_req = (c % 2 == 0);
        tick();
        pix_req = 0;
      end
    end
    check("fs_fetch_in_flight", found, 1'b1);
    frame_start = 1; pix_req = 1;
    tick();
    frame_start = 0; pix_req = 0;
    check("fs_underflow_clear", underflow, 1'b0);
    check("fs_no_pop", pix_valid, 1'b0);
    repeat (3) tick();
    for (int k = 0; k < 6; k++) begin
      pix_req = 1;
      tick();
      pix_req = 0;
      check("fs_pop_data", pix_data, 32'(k));
      check("fs_pop_valid", pix_valid, 1'b1);
      tick();
    end
    check("fs_underflow_after", underflow, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port video RAM between the VGA scan-out path and the CPU bus. Keeps a small pixel prefetch FIFO ahead of the display timing generator, which pops one word per pixel. CPU reads and writes are granted into the remaining memory cycles. Sits between the VGA timing/colour path, the CPU memory-mapped video window, and the framebuffer RAM.

## Interface
- ADDR_W, 16, framebuffer word address width
- DATA_W, 16, framebuffer word width
- FB_WORDS, 19200, framebuffer size in words; the fetch address wraps at FB_WORDS-1
- FIFO_DEPTH, 4, prefetch FIFO entries (power of 2, ≥2)
- LOW_WATER, 2, fill-priority threshold (1..FIFO_DEPTH-1)
- STARVE_LIMIT, 8, CPU wait cycles before the forced grant (guard builds only)

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at the start of a frame; restarts fetch at address 0
- pix_req  in  1  pop one pixel word
- pix_data  out  DATA_W  popped word, registered
- pix_valid  out  1  pix_data was popped from a non-empty FIFO this cycle
- underflow  out  1  sticky flag: a pix_req arrived while the FIFO was empty
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack is high
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, one cycle after the address

## Operation
- The arbiter issues at most one RAM access per cycle. The FSM states are IDLE, FETCH and CPU, and each names the access issued in the current cycle.
- occ = FIFO level + in-flight fetch reads (0 or 1).
- Grant priority is evaluated every cycle, in this order:
  1. occ < LOW_WATER: FETCH.
  2. cpu_req high and no cpu_ack this cycle: CPU.
  3. occ < FIFO_DEPTH: FETCH.
  4. Otherwise: IDLE.
- FETCH: drives mem_addr = fetch_addr with mem_we = 0, then increments fetch_addr. fetch_addr wraps from FB_WORDS-1 to 0. The data is pushed into the FIFO on the next cycle.
- CPU: drives mem_addr = cpu_addr and mem_we = cpu_we, with mem_wdata = cpu_wdata. cpu_ack pulses on the next cycle, and for a read cpu_rdata = mem_rdata in that cycle. The arbiter does not grant the CPU again in the cycle in which cpu_ack is high, which prevents a double issue.
- Pop on pix_req:
  - FIFO non-empty: pix_data gets the head entry and pix_valid = 1 on the next cycle.
  - FIFO empty: pix_valid = 0, pix_data holds its previous value, and underflow is set.
- A push and a pop in the same cycle are both performed and the level does not change.
- frame_start has priority over everything else in its cycle. It:
  - flushes the FIFO;
  - sets fetch_addr to 0;
  - marks any in-flight fetch as discarded, so that read is not pushed;
  - clears underflow;
  - ignores a pix_req arriving in the same cycle.
  A CPU access already issued still completes.
- A CPU access is never dropped once granted.
- Reset mid-access abandons it with no cpu_ack.

## Timing
- Reset values: all outputs are 0, the FIFO is empty, fetch_addr = 0, and the state is IDLE.
- Fetch latency: the address is issued in cycle N and the word is in the FIFO at the end of N+1.
- Pop latency: pix_req in N gives pix_data and pix_valid in N+1.
- CPU latency: with no contention, cpu_req is granted in the same cycle N and cpu_ack comes in N+1. Worst case (strict build): the CPU waits while occ < LOW_WATER, which is bounded because a fill needs at most LOW_WATER cycles.
- Back-to-back CPU accesses complete at most every 2 cycles.
- Sustained pixel rate: 1 pop per 2 clk at 25 MHz. This leaves at least 1 in 2 cycles for the CPU when the FIFO is at steady state.

## Configuration
- VRAM_ARB_STARVE_GUARD_EN defined:
  - A counter tracks the cycles cpu_req has been pending without a grant.
  - When it reaches STARVE_LIMIT, the CPU wins priority rule 1 unless FIFO level == 0.
  - The counter clears on the grant and on rst.
- VRAM_ARB_STARVE_GUARD_EN undefined: strict priority as listed, with no counter and no STARVE_LIMIT logic.

## Test plan
- Reset, idle 10 cycles:
  - FIFO fills to 4 with mem_addr 0,1,2,3 issued on consecutive cycles.
  - Then IDLE, with mem_we = 0 throughout.
- RAM preloaded addr = data, pix_req every 2nd cycle for 20 pops → pix_data = 0..19 in order, pix_valid each time, underflow = 0.
- CPU write 0xBEEF to 0x0040 while popping, then CPU read of 0x0040:
  - cpu_ack 1 cycle after each grant;
  - cpu_rdata = 0xBEEF;
  - no pixel underflow.
- FB_WORDS = 8, 12 pops → pix_data 0..7, 0..3 (wrap).
- frame_start with a fetch in flight and a simultaneous pix_req:
  - the next pops return words 0,1,2…;
  - the discarded word never appears;
  - underflow is cleared.
- pix_req held every cycle with cpu_req held continuously:
  - underflow is set and sticky until frame_start.
  - Guard build: the CPU is granted within STARVE_LIMIT+1 cycles.
  - Strict build: the CPU is granted only when occ ≥ LOW_WATER.
